// File: rtl/noc_router_output_arb.sv
// noc_router_output_arb
// Output-port stage of the NoC router. Picks one requesting input per packet
// (round-robin between packets) and keeps that input granted until its last
// flit has been accepted. Accepted flits go into a small FIFO that drives the
// link towards the next router.
// Optional build macro: NOC_ROUTER_OUT_STATS_EN adds the pkt_count output,
// which counts packets whose last flit has left the FIFO.
module noc_router_output_arb #(
    parameter int FLIT_WIDTH   = 32,
    parameter int INPUTS       = 5,
    parameter int BUFFER_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [INPUTS*FLIT_WIDTH-1:0] in_flit,
    input  logic [INPUTS-1:0]            in_last,
    input  logic [INPUTS-1:0]            in_valid,
    output logic [INPUTS-1:0]            in_ready,
    output logic [FLIT_WIDTH-1:0]        out_flit,
    output logic                         out_last,
    output logic                         out_valid,
    input  logic                         out_ready
`ifdef NOC_ROUTER_OUT_STATS_EN
    ,
    output logic [31:0]                  pkt_count
`endif
);

    localparam int IW = (INPUTS > 1) ? $clog2(INPUTS) : 1;
    localparam int PW = $clog2(BUFFER_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(INPUTS - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(BUFFER_DEPTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WORM = 1'b1;

    // Next input index with wrap, usable for any INPUTS (not only powers of 2).
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        logic [IW-1:0] res;
        if (idx == LAST_IDX) begin
            res = {IW{1'b0}};
        end else begin
            res = idx + IW'(1);
        end
        return res;
    endfunction

    logic [0:0]            state_r;
    logic [IW-1:0]         grant_r;
    logic [IW-1:0]         rr_r;
    logic [PW-1:0]         wr_ptr_r;
    logic [PW-1:0]         rd_ptr_r;
    logic [CW-1:0]         count_r;
    logic [FLIT_WIDTH:0]   mem_r [BUFFER_DEPTH];

    logic                  win_found_s;
    logic [IW-1:0]         win_idx_s;
    logic [IW-1:0]         cand_s;
    logic [IW-1:0]         sel_s;
    logic                  sel_req_s;
    logic                  full_s;
    logic                  empty_s;
    logic                  push_s;
    logic                  pop_s;
    logic [FLIT_WIDTH-1:0] push_flit_s;
    logic                  push_last_s;
    logic [INPUTS-1:0]     in_ready_s;
    logic [FLIT_WIDTH:0]   head_s;

    // Round-robin search: first valid input starting at the rr pointer, wrapping.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = {IW{1'b0}};
        cand_s      = rr_r;
        for (int k = 0; k < INPUTS; k++) begin
            if (!win_found_s && in_valid[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
            cand_s = next_idx(cand_s);
        end
    end

    // Pick the input being served this cycle and form the push/pop strobes.
    // Readiness never looks at out_ready or at any flit/last payload bits.
    always_comb begin
        if (state_r == ST_WORM) begin
            sel_s     = grant_r;
            sel_req_s = in_valid[grant_r];
        end else begin
            sel_s     = win_idx_s;
            sel_req_s = win_found_s;
        end
        full_s      = (count_r == DEPTH_C);
        empty_s     = (count_r == {CW{1'b0}});
        push_s      = rst_n & sel_req_s & ~full_s;
        pop_s       = ~empty_s & out_ready;
        push_flit_s = in_flit[sel_s*FLIT_WIDTH +: FLIT_WIDTH];
        push_last_s = in_last[sel_s];
        in_ready_s  = {INPUTS{1'b0}};
        in_ready_s[sel_s] = push_s;
    end

    assign in_ready = in_ready_s;

    // FIFO pointers, occupancy and the packet-lock state machine.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            grant_r  <= {IW{1'b0}};
            rr_r     <= {IW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r <= count_r + CW'(push_s) - CW'(pop_s);

            case (state_r)
                ST_IDLE: begin
                    if (push_s && push_last_s) begin
                        rr_r <= next_idx(sel_s);
                    end else if (push_s) begin
                        state_r <= ST_WORM;
                        grant_r <= sel_s;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WORM: begin
                    if (push_s && push_last_s) begin
                        state_r <= ST_IDLE;
                        rr_r    <= next_idx(grant_r);
                    end else begin
                        state_r <= ST_WORM;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // FIFO storage: {last, flit} written at the tail on each accepted flit.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {push_last_s, push_flit_s};
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Head of the FIFO; outputs read as zero while empty so stale entries never show.
    always_comb begin
        head_s = mem_r[rd_ptr_r];
        if (empty_s) begin
            out_valid = 1'b0;
            out_flit  = {FLIT_WIDTH{1'b0}};
            out_last  = 1'b0;
        end else begin
            out_valid = 1'b1;
            out_flit  = head_s[FLIT_WIDTH-1:0];
            out_last  = head_s[FLIT_WIDTH];
        end
    end

`ifdef NOC_ROUTER_OUT_STATS_EN
    // Count packets whose last flit leaves the FIFO; wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_count <= 32'd0;
        end else if (pop_s && head_s[FLIT_WIDTH]) begin
            pkt_count <= pkt_count + 32'd1;
        end else begin
            pkt_count <= pkt_count;
        end
    end
`else
    // Statistics counter not built in this configuration.
`endif

endmodule

// File: tb/tb_noc_router_output_arb.sv
// Testbench for noc_router_output_arb: directed scenarios with literal
// expectations followed by randomized traffic, all checked every cycle
// against a packet-level model (per-input packet queues, a FIFO queue,
// a lock owner and a round-robin pointer).
module tb_noc_router_output_arb;

    localparam int FW = 32;
    localparam int NI = 5;
    localparam int BD = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NI*FW-1:0]  in_flit;
    logic [NI-1:0]     in_last;
    logic [NI-1:0]     in_valid;
    logic [NI-1:0]     in_ready;
    logic [FW-1:0]     out_flit;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;
`ifdef NOC_ROUTER_OUT_STATS_EN
    logic [31:0]       pkt_count;
`endif

    always #5 clk = ~clk;

    noc_router_output_arb #(.FLIT_WIDTH(FW), .INPUTS(NI), .BUFFER_DEPTH(BD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_flit   (in_flit),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_flit  (out_flit),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef NOC_ROUTER_OUT_STATS_EN
        ,
        .pkt_count (pkt_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Upstream packets waiting per input, and the model's view of the FIFO.
    logic [FW:0] dq [NI][$];
    logic [FW:0] mq [$];
    bit          locked;
    int          owner;
    int          rr;
    int          mpkt;
    int          log_q [$];
    int          vld_pct;
    int          ord_pct;
    logic [NI-1:0] last_acc;
    logic        obs_ov;
    logic [FW-1:0] obs_of;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int getlog(input int k);
        return (k < log_q.size()) ? log_q[k] : -1;
    endfunction

    task automatic add_pkt(input int i, input int len, input logic [FW-1:0] base);
        for (int j = 0; j < len; j++) begin
            dq[i].push_back({(j == len - 1) ? 1'b1 : 1'b0, base + FW'(j)});
        end
    endtask

    // Drive upstream inputs; a presented-but-unaccepted flit stays presented and stable.
    task automatic drive();
        for (int i = 0; i < NI; i++) begin
            bit hold;
            bit v;
            hold = in_valid[i] && !last_acc[i];
            v = (dq[i].size() > 0) && (hold || ($urandom_range(99) < vld_pct));
            in_valid[i] = v;
            if (v) begin
                in_flit[i*FW +: FW] = dq[i][0][FW-1:0];
                in_last[i]          = dq[i][0][FW];
            end else begin
                in_flit[i*FW +: FW] = $urandom;
                in_last[i]          = 1'($urandom_range(1));
            end
        end
        out_ready = ($urandom_range(99) < ord_pct);
    endtask

    // One cycle: drive, check DUT against the model at negedge, advance the model after posedge.
    task automatic step();
        logic [NI-1:0] exp_rdy;
        int idx;
        bit pop;
        logic [FW:0] f;
        drive();
        @(negedge clk);
        exp_rdy = '0;
        idx = -1;
        if (rst_n && mq.size() < BD) begin
            if (locked) begin
                if (in_valid[owner]) idx = owner;
            end else begin
                for (int k = 0; k < NI; k++) begin
                    int j;
                    j = (rr + k) % NI;
                    if (idx < 0 && in_valid[j]) idx = j;
                end
            end
        end
        if (idx >= 0) exp_rdy[idx] = 1'b1;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        if (mq.size() > 0) begin
            chk("out_valid", 64'(out_valid), 64'd1);
            chk("out_flit", 64'(out_flit), 64'(mq[0][FW-1:0]));
            chk("out_last", 64'(out_last), 64'(mq[0][FW]));
        end else begin
            chk("out_valid", 64'(out_valid), 64'd0);
            chk("out_flit", 64'(out_flit), 64'd0);
            chk("out_last", 64'(out_last), 64'd0);
        end
`ifdef NOC_ROUTER_OUT_STATS_EN
        if (rst_n) chk("pkt_count", 64'(pkt_count), 64'(mpkt));
`endif
        obs_ov = out_valid;
        obs_of = out_flit;
        for (int i = 0; i < NI; i++) begin
            if (in_ready[i]) log_q.push_back(i);
        end
        pop = rst_n && out_ready && (mq.size() > 0);
        @(posedge clk);
        #1;
        last_acc = exp_rdy;
        if (!rst_n) begin
            mq.delete();
            locked = 1'b0;
            rr     = 0;
            mpkt   = 0;
        end else begin
            if (pop) begin
                if (mq[0][FW]) mpkt++;
                void'(mq.pop_front());
            end
            if (idx >= 0) begin
                f = dq[idx].pop_front();
                mq.push_back(f);
                if (!locked) begin
                    if (f[FW]) rr = (idx + 1) % NI;
                    else begin
                        locked = 1'b1;
                        owner  = idx;
                    end
                end else if (f[FW]) begin
                    locked = 1'b0;
                    rr     = (owner + 1) % NI;
                end
            end
        end
    endtask

    // One reset cycle; upstream queues are flushed together with the router.
    task automatic rst_seq();
        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) dq[i].delete();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int exp2 [6] = '{0, 0, 0, 3, 3, 3};
        int exp3 [3] = '{0, 1, 4};
        bit drained;
        rst_n = 1'b0;
        in_flit = '0;
        in_last = '0;
        in_valid = '0;
        out_ready = 1'b0;
        last_acc = '0;
        locked = 1'b0;
        owner = 0;
        rr = 0;
        mpkt = 0;
        vld_pct = 100;
        ord_pct = 100;
        repeat (2) @(posedge clk);
        #1;
        rst_seq();

        // Single-flit packet on input 2.
        add_pkt(2, 1, 32'hA5A5_0002);
        log_q.delete();
        step();
        chk("t1_grant", 64'(getlog(0)), 64'd2);
        step();
        chk("t1_out_valid", 64'(obs_ov), 64'd1);
        chk("t1_out_flit", 64'(obs_of), 64'hA5A5_0002);
        chk("t1_model_rr", 64'(rr), 64'd3);
        add_pkt(2, 1, 32'h22);
        add_pkt(3, 1, 32'h33);
        log_q.delete();
        step();
        chk("t1_rr_next", 64'(getlog(0)), 64'd3);
        repeat (3) step();

        // Two 3-flit packets competing, no interleaving.
        rst_seq();
        add_pkt(0, 3, 32'h100);
        add_pkt(3, 3, 32'h300);
        log_q.delete();
        repeat (8) step();
        for (int k = 0; k < 6; k++) chk("t2_order", 64'(getlog(k)), 64'(exp2[k]));

        // Fairness with continuous single-flit requests.
        rst_seq();
        for (int k = 0; k < 6; k++) begin
            add_pkt(0, 1, 32'h1000 + 32'(k));
            add_pkt(1, 1, 32'h1100 + 32'(k));
            add_pkt(4, 1, 32'h1400 + 32'(k));
        end
        log_q.delete();
        repeat (20) step();
        for (int k = 0; k < 9; k++) chk("t3_rr_order", 64'(getlog(k)), 64'(exp3[k % 3]));

        // Backpressure: a 6-flit packet into a 4-deep FIFO.
        rst_seq();
        ord_pct = 0;
        add_pkt(2, 6, 32'h400);
        log_q.delete();
        repeat (8) step();
        chk("t4_fill", 64'(log_q.size()), 64'd4);
        ord_pct = 100;
        repeat (10) step();
        chk("t4_total", 64'(log_q.size()), 64'd6);

        // Reset in the middle of a worm.
        rst_seq();
        ord_pct = 0;
        add_pkt(0, 5, 32'h500);
        log_q.delete();
        repeat (2) step();
        chk("t5_partial", 64'(log_q.size()), 64'd2);
        rst_seq();
        chk("t5_out_valid", 64'(out_valid), 64'd0);
        ord_pct = 100;
        add_pkt(1, 1, 32'h501);
        add_pkt(4, 1, 32'h504);
        log_q.delete();
        step();
        chk("t5_grant", 64'(getlog(0)), 64'd1);
        repeat (4) step();

`ifdef NOC_ROUTER_OUT_STATS_EN
        // Packet counter after three drained packets.
        rst_seq();
        add_pkt(0, 2, 32'h600);
        add_pkt(2, 1, 32'h620);
        add_pkt(3, 3, 32'h630);
        repeat (12) step();
        chk("t6_pkt_count", 64'(pkt_count), 64'd3);
`endif

        // Randomized traffic with occasional resets.
        rst_seq();
        vld_pct = 60;
        ord_pct = 70;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NI; i++) begin
                if (dq[i].size() == 0 && $urandom_range(99) < 20) begin
                    add_pkt(i, 1 + $urandom_range(3), $urandom);
                end
            end
            if ($urandom_range(499) == 0) rst_seq();
            else step();
        end

        // Drain within a bounded number of cycles.
        vld_pct = 100;
        ord_pct = 100;
        repeat (80) step();
        drained = (mq.size() == 0);
        for (int i = 0; i < NI; i++) if (dq[i].size() != 0) drained = 1'b0;
        chk("drain", 64'(drained), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
